sr_cmd_gen: RTL and testbench

//  Upstream command stage for the SR flip-flop (srff). Takes two raw, bouncy

---
 rtl/sr_cmd_gen_pkg.sv | 20 ++
 rtl/sr_cmd_gen_if.sv | 19 +
 rtl/sr_cmd_gen_debounce.sv | 55 +++++
 rtl/sr_cmd_gen.sv | 105 ++++++++++
 tb/tb_sr_cmd_gen.sv | 382 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sr_cmd_gen_pkg.sv
// Shared types and helpers for the s/r command generator.
// The FSM state encoding and counter-width helper live here so every block agrees on them.
package sr_cmd_gen_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSetP = 2'd1,
    StClrP = 2'd2,
    StGap  = 2'd3
  } state_e;

  // Bits needed to hold values 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int unsigned DEB_CNT_W_DEF   = cnt_width(4);
  localparam int unsigned PULSE_CNT_W_DEF = cnt_width(2);

endpackage

// File: rtl/sr_cmd_gen_if.sv
// Request/command bundle between the request source (master) and sr_cmd_gen (slave).
interface sr_cmd_gen_if;
  logic set_req;
  logic clr_req;
  logic s;
  logic r;
  logic busy;
  logic conflict;

  modport master (
    output set_req, clr_req,
    input  s, r, busy, conflict
  );

  modport slave (
    input  set_req, clr_req,
    output s, r, busy, conflict
  );
endinterface

// File: rtl/sr_cmd_gen_debounce.sv
// 2-FF synchroniser, stable-count debouncer and rising-edge detect for one raw request line.
module sr_cmd_gen_debounce
  import sr_cmd_gen_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_din,
  output logic o_rise
);

  localparam int unsigned      CntW    = cnt_width(DEB_CYCLES);
  localparam logic [CntW-1:0]  CntLast = CntW'(DEB_CYCLES - 1);

  logic            r_meta;
  logic            r_sync;
  logic            r_level;
  logic [CntW-1:0] r_cnt;

  logic            w_flip;
  logic [CntW-1:0] w_cnt_d;

  // The level flips on the DEB_CYCLES-th consecutive differing sample.
  always_comb begin
    w_flip  = 1'b0;
    w_cnt_d = '0;
    if (r_sync != r_level) begin
      if (r_cnt == CntLast) begin
        w_flip = 1'b1;
      end else begin
        w_cnt_d = r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_meta  <= i_din;
      r_sync  <= r_meta;
      r_cnt   <= w_cnt_d;
      if (w_flip) begin
        r_level <= r_sync;
      end
    end
  end

  assign o_rise = w_flip & r_sync;

endmodule

// File: rtl/sr_cmd_gen.sv
// Turns bouncy set/clear request lines into clean, mutually exclusive fixed-width s/r pulses
// with per-type pending flags, a one-cycle gap between pulses and a same-cycle conflict flag.
module sr_cmd_gen
  import sr_cmd_gen_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned PULSE_LEN  = 2,
  parameter bit          PRIO_SET   = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  sr_cmd_gen_if.slave io_bus
);

  localparam int unsigned       PulseW    = cnt_width(PULSE_LEN);
  localparam logic [PulseW-1:0] PulseLast = PulseW'(PULSE_LEN - 1);

  logic              w_rise_set;
  logic              w_rise_clr;

  state_e            r_state;
  state_e            w_state_d;
  logic [PulseW-1:0] r_pcnt;
  logic [PulseW-1:0] w_pcnt_d;
  logic              r_pend_set;
  logic              r_pend_clr;
  logic              w_pend_set_d;
  logic              w_pend_clr_d;
  logic              w_take_set;
  logic              w_take_clr;
  logic              r_conflict;

  sr_cmd_gen_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb_set (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_din  (io_bus.set_req),
    .o_rise (w_rise_set)
  );

  sr_cmd_gen_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb_clr (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_din  (io_bus.clr_req),
    .o_rise (w_rise_clr)
  );

  always_comb begin
    w_state_d  = r_state;
    w_pcnt_d   = r_pcnt;
    w_take_set = 1'b0;
    w_take_clr = 1'b0;
    unique case (r_state)
      StIdle, StGap: begin
        if (r_pend_set && (PRIO_SET || !r_pend_clr)) begin
          w_take_set = 1'b1;
          w_state_d  = StSetP;
          w_pcnt_d   = PulseLast;
        end else if (r_pend_clr) begin
          w_take_clr = 1'b1;
          w_state_d  = StClrP;
          w_pcnt_d   = PulseLast;
        end else begin
          w_state_d = StIdle;
        end
      end
      StSetP, StClrP: begin
        if (r_pcnt == '0) begin
          w_state_d = StGap;
        end else begin
          w_pcnt_d = r_pcnt - 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
    // A fresh edge in the service cycle re-arms the flag.
    w_pend_set_d = (r_pend_set & ~w_take_set) | w_rise_set;
    w_pend_clr_d = (r_pend_clr & ~w_take_clr) | w_rise_clr;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_pcnt     <= '0;
      r_pend_set <= 1'b0;
      r_pend_clr <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_pcnt     <= w_pcnt_d;
      r_pend_set <= w_pend_set_d;
      r_pend_clr <= w_pend_clr_d;
      r_conflict <= w_rise_set & w_rise_clr;
    end
  end

  assign io_bus.s        = (r_state == StSetP);
  assign io_bus.r        = (r_state == StClrP);
  assign io_bus.busy     = (r_state != StIdle) | r_pend_set | r_pend_clr;
  assign io_bus.conflict = r_conflict;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Bench for sr_cmd_gen: three instances (clear-priority, set-priority, long pulse) driven by
// shared request lines and compared every cycle against a schedule-based reference model.
module tb_sr_cmd_gen;

  localparam int unsigned Deb  = 4;
  localparam int          NDut = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic set_req;
  logic clr_req;
  logic chain_q = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sr_cmd_gen_if bus0 ();
  sr_cmd_gen_if bus1 ();
  sr_cmd_gen_if bus2 ();

  assign bus0.set_req = set_req;
  assign bus0.clr_req = clr_req;
  assign bus1.set_req = set_req;
  assign bus1.clr_req = clr_req;
  assign bus2.set_req = set_req;
  assign bus2.clr_req = clr_req;

  sr_cmd_gen #(.DEB_CYCLES(Deb), .PULSE_LEN(2), .PRIO_SET(1'b0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .io_bus(bus0)
  );
  sr_cmd_gen #(.DEB_CYCLES(Deb), .PULSE_LEN(2), .PRIO_SET(1'b1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .io_bus(bus1)
  );
  sr_cmd_gen #(.DEB_CYCLES(Deb), .PULSE_LEN(32), .PRIO_SET(1'b0)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .io_bus(bus2)
  );

  // Downstream SR flip-flop fed by dut0.
  always @(posedge clk) begin
    if (bus0.s) chain_q <= 1'b1;
    else if (bus0.r) chain_q <= 1'b0;
  end

  assert property (@(posedge clk) !(bus0.s && bus0.r)) else $error("s and r both high on dut0");
  assert property (@(posedge clk) !(bus1.s && bus1.r)) else $error("s and r both high on dut1");
  assert property (@(posedge clk) !(bus2.s && bus2.r)) else $error("s and r both high on dut2");

  // ---------------- reference model ----------------
  bit          m_ff1  [2];
  bit          m_sync [2];
  bit          m_lvl  [2];
  logic [31:0] m_hist [2];
  bit          m_pend [NDut][2];
  bit          m_eng  [NDut];
  bit          m_kset [NDut];
  int          m_start[NDut];
  bit          m_conf;
  int          cyc;

  function automatic int pl_of(input int d);
    return (d == 2) ? 32 : 2;
  endfunction

  function automatic bit prio_of(input int d);
    return (d == 1);
  endfunction

  function automatic byte m_out(input int d);
    if (!m_eng[d]) return "I";
    if (cyc - m_start[d] < pl_of(d)) return m_kset[d] ? "S" : "R";
    return "G";
  endfunction

  function automatic logic [11:0] exp_vec();
    logic [11:0] v;
    byte o;
    for (int d = 0; d < NDut; d++) begin
      o = m_out(d);
      v[11-4*d -: 4] = {o == "S", o == "R", (o != "I") || m_pend[d][0] || m_pend[d][1], m_conf};
    end
    return v;
  endfunction

  function automatic logic [11:0] dut_vec();
    return {bus0.s, bus0.r, bus0.busy, bus0.conflict,
            bus1.s, bus1.r, bus1.busy, bus1.conflict,
            bus2.s, bus2.r, bus2.busy, bus2.conflict};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ff1[i] = 0; m_sync[i] = 0; m_lvl[i] = 0; m_hist[i] = '0;
    end
    for (int d = 0; d < NDut; d++) begin
      m_pend[d][0] = 0; m_pend[d][1] = 0; m_eng[d] = 0; m_kset[d] = 0; m_start[d] = 0;
    end
    m_conf = 0;
    cyc = 0;
  endtask

  // One clock edge: the last DEB synchronised samples decide a level change; a pulse
  // occupies cycles [start, start+PL) followed by one gap cycle.
  task automatic model_step(input bit raw_s, input bit raw_c);
    bit rise [2];
    bit raw, sync_old, prev_free, take_s, take_c;
    logic [31:0] mask;
    mask = (32'h1 << Deb) - 32'h1;
    for (int i = 0; i < 2; i++) begin
      raw       = (i == 0) ? raw_s : raw_c;
      sync_old  = m_sync[i];
      m_sync[i] = m_ff1[i];
      m_ff1[i]  = raw;
      m_hist[i] = {m_hist[i][30:0], sync_old};
      rise[i]   = 0;
      if ((m_hist[i] & mask) == (m_lvl[i] ? 32'h0 : mask)) begin
        m_lvl[i] = !m_lvl[i];
        rise[i]  = m_lvl[i];
      end
    end
    cyc++;
    for (int d = 0; d < NDut; d++) begin
      prev_free = !m_eng[d] || (cyc - 1 - m_start[d] >= pl_of(d));
      if (prev_free) begin
        take_s = m_pend[d][0] && (prio_of(d) || !m_pend[d][1]);
        take_c = !take_s && m_pend[d][1];
        if (take_s || take_c) begin
          m_eng[d]   = 1;
          m_start[d] = cyc;
          m_kset[d]  = take_s;
          if (take_s) m_pend[d][0] = 0;
          else m_pend[d][1] = 0;
        end else begin
          m_eng[d] = 0;
        end
      end
      m_pend[d][0] = m_pend[d][0] | rise[0];
      m_pend[d][1] = m_pend[d][1] | rise[1];
    end
    m_conf = rise[0] & rise[1];
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(set_req, clr_req);
    #1;
  endtask

  task automatic apply_reset();
    rst_n   = 1'b0;
    set_req = 1'b0;
    clr_req = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    checks++;
    if (dut_vec() !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs got %b want %b", dut_vec(), 12'h000);
    end
    for (int n = 0; n < 8; n++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_idle cyc %0d got %b want %b", n, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_single_set();
    apply_reset();
    set_req = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      tick();
      if (n == 10) set_req = 1'b0;
      checks++;
      if (bus0.s !== ((n == 7) || (n == 8)) || bus0.r !== 1'b0) begin
        errors++;
        $display("FAIL single_set_sr cyc %0d got s=%b r=%b want s=%b r=0", n, bus0.s, bus0.r,
                 (n == 7) || (n == 8));
      end
      checks++;
      if (bus0.busy !== ((n >= 6) && (n <= 9))) begin
        errors++;
        $display("FAIL single_set_busy cyc %0d got %b want %b", n, bus0.busy,
                 (n >= 6) && (n <= 9));
      end
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL single_set_model cyc %0d got %b want %b", n, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_glitch();
    apply_reset();
    set_req = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (n == 3) set_req = 1'b0;
      checks++;
      if (dut_vec() !== 12'h000) begin
        errors++;
        $display("FAIL glitch_reject cyc %0d got %b want %b", n, dut_vec(), 12'h000);
      end
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL glitch_model cyc %0d got %b want %b", n, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [4:0] got, want;
    apply_reset();
    set_req = 1'b1;
    clr_req = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      tick();
      if (n == 10) begin
        set_req = 1'b0;
        clr_req = 1'b0;
      end
      got  = {bus0.conflict, bus0.s, bus0.r, bus1.s, bus1.r};
      want = {n == 6, (n == 10) || (n == 11), (n == 7) || (n == 8),
              (n == 7) || (n == 8), (n == 10) || (n == 11)};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL simultaneous cyc %0d got %b want %b", n, got, want);
      end
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL simultaneous_model cyc %0d got %b want %b", n, dut_vec(), exp_vec());
      end
    end
  endtask

  // Three debounced set edges; on the long-pulse instance edges 2 and 3 land in SET_P.
  task automatic test_coalesce();
    int pulses0, pulses2;
    logic prev0, prev2;
    apply_reset();
    pulses0 = 0;
    pulses2 = 0;
    prev0   = 1'b0;
    prev2   = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      set_req = (((n - 1) % 12) < 6) && (n - 1 < 30);
      tick();
      if (bus0.s && !prev0) pulses0++;
      if (bus2.s && !prev2) pulses2++;
      prev0 = bus0.s;
      prev2 = bus2.s;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL coalesce_model cyc %0d got %b want %b", n, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (pulses2 !== 2) begin
      errors++;
      $display("FAIL coalesce_long got %0d pulses want 2", pulses2);
    end
    checks++;
    if (pulses0 !== 3) begin
      errors++;
      $display("FAIL coalesce_short got %0d pulses want 3", pulses0);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_req = 1'b1;
    repeat (7) tick();
    checks++;
    if (bus0.s !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_pre got s=%b want 1", bus0.s);
    end
    #3;
    rst_n   = 1'b0;
    set_req = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== 12'h000) begin
      errors++;
      $display("FAIL mid_reset_async got %b want %b", dut_vec(), 12'h000);
    end
    @(posedge clk);
    model_reset();
    #1;
    rst_n = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      checks++;
      if (dut_vec() !== 12'h000 || dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL mid_reset_after cyc %0d got %b want %b", n, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_chain();
    apply_reset();
    clr_req = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (n == 10) clr_req = 1'b0;
    end
    checks++;
    if (chain_q !== 1'b0) begin
      errors++;
      $display("FAIL chain_clear got q=%b want 0", chain_q);
    end
    set_req = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (n == 10) set_req = 1'b0;
    end
    checks++;
    if (chain_q !== 1'b1) begin
      errors++;
      $display("FAIL chain_set got q=%b want 1", chain_q);
    end
  endtask

  task automatic test_random();
    int hold_s, hold_c;
    apply_reset();
    hold_s = 0;
    hold_c = 0;
    for (int n = 1; n <= 1500; n++) begin
      if (hold_s == 0) begin
        set_req = $urandom_range(0, 1);
        hold_s  = $urandom_range(1, 9);
      end
      if (hold_c == 0) begin
        clr_req = $urandom_range(0, 1);
        hold_c  = $urandom_range(1, 9);
      end
      hold_s--;
      hold_c--;
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random_model cyc %0d got %b want %b", n, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    set_req = 1'b0;
    clr_req = 1'b0;
    model_reset();
    test_reset();
    test_single_set();
    test_glitch();
    test_simultaneous();
    test_coalesce();
    test_reset_mid();
    test_chain();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
